// File: rtl/ftdi_sync_rx.sv
// FT232H 245-sync-FIFO receive engine: drains host bytes via OE#/RD# into a
// first-word-fall-through FIFO presented as a valid/ready byte stream.
module ftdi_sync_rx #(
    parameter int unsigned DEPTH = 16
) (
    input  logic       ftdiclk,
    input  logic       reset,
    input  logic       ftdi_rxf_n,
    input  logic [7:0] ftdi_data_in,
    output logic       ftdi_oe_n,
    output logic       ftdi_rd_n,
    input  logic       rx_inhibit,
    output logic       bus_busy,
    output logic [7:0] m_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic       overflow
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W  = ADDR_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TURN = 2'd1,
        READ = 2'd2
    } state_t;

    state_t            state_q;
    logic              oe_n_q;
    logic              rd_n_q;
    logic              busy_q;
    logic              ovf_q;
    logic [7:0]        mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q;
    logic [ADDR_W-1:0] wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q;
    logic [ADDR_W-1:0] rd_ptr_d;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic              room;
    logic              full;
    logic              push;
    logic              pop;
    logic              wr_en;

    // Two slots of headroom cover the byte still on the bus when RD# is released.
    assign room  = count_q < CNT_W'(DEPTH - 2);
    assign full  = count_q == CNT_W'(DEPTH);
    assign push  = ~rd_n_q & ~ftdi_rxf_n;
    assign pop   = (count_q != '0) & m_ready;
    assign wr_en = push & ~full;

    assign ftdi_oe_n = oe_n_q;
    assign ftdi_rd_n = rd_n_q;
    assign bus_busy  = busy_q;
    assign overflow  = ovf_q;
    assign m_valid   = count_q != '0;
    assign m_data    = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q + ADDR_W'(wr_en);
        rd_ptr_d = rd_ptr_q + ADDR_W'(pop);
        count_d  = count_q + CNT_W'(wr_en) - CNT_W'(pop);
    end

    // Bus handshake: IDLE -> TURN (OE# low) -> READ (RD# low) -> back to IDLE.
    always_ff @(posedge ftdiclk) begin
        if (reset) begin
            state_q <= IDLE;
            oe_n_q  <= 1'b1;
            rd_n_q  <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (~ftdi_rxf_n && room && ~rx_inhibit) begin
                        state_q <= TURN;
                        oe_n_q  <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                TURN: begin
                    if (ftdi_rxf_n || rx_inhibit) begin
                        state_q <= IDLE;
                        oe_n_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= READ;
                        rd_n_q  <= 1'b0;
                    end
                end
                READ: begin
                    if (ftdi_rxf_n || !room || rx_inhibit) begin
                        state_q <= IDLE;
                        oe_n_q  <= 1'b1;
                        rd_n_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    oe_n_q  <= 1'b1;
                    rd_n_q  <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge ftdiclk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push && full) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // Storage carries no reset; the flushed pointers make stale contents invisible.
    always_ff @(posedge ftdiclk) begin
        if (wr_en && !reset) begin
            mem_q[wr_ptr_q] <= ftdi_data_in;
        end
    end

endmodule

// File: tb/tb_ftdi_sync_rx.sv
// Bench for ftdi_sync_rx: FTDI host model feeding byte queues, a per-cycle
// bus-protocol/scoreboard monitor, and directed plus randomized scenarios.
`timescale 1ns/1ps
module tb_ftdi_sync_rx;

    localparam int DEPTH = 16;

    typedef logic [7:0] byte_q_t [$];
    typedef struct {
        logic       rst, rxf_n, inh, m_ready, oe_n, rd_n, busy, m_valid, ovf;
        logic [7:0] data, m_data;
    } samp_t;

    logic       ftdiclk = 1'b0;
    logic       reset = 1'b1;
    logic       ftdi_rxf_n = 1'b1;
    logic       rx_inhibit = 1'b0;
    logic       m_ready = 1'b0;
    logic       host_hold = 1'b0;
    logic       host_cap;
    logic [7:0] ftdi_data_in = 8'h00;
    logic [7:0] m_data;
    logic       ftdi_oe_n, ftdi_rd_n, bus_busy, m_valid, overflow;

    int      tests = 0;
    int      fails = 0;
    int      cyc = 0;
    int      mon_occ;
    bit      mon_room;
    bit      mon_en = 1'b0;
    byte_q_t host_q, exp_q, got_q, sent_q;
    samp_t   prev_s, cur_s;

    ftdi_sync_rx #(.DEPTH(DEPTH)) dut (
        .ftdiclk     (ftdiclk),
        .reset       (reset),
        .ftdi_rxf_n  (ftdi_rxf_n),
        .ftdi_data_in(ftdi_data_in),
        .ftdi_oe_n   (ftdi_oe_n),
        .ftdi_rd_n   (ftdi_rd_n),
        .rx_inhibit  (rx_inhibit),
        .bus_busy    (bus_busy),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .overflow    (overflow)
    );

    always #5 ftdiclk = ~ftdiclk;
    always @(posedge ftdiclk) cyc++;

    task automatic host_drive();
        ftdi_rxf_n   = host_hold || (host_q.size() == 0);
        ftdi_data_in = (host_q.size() != 0) ? host_q[0] : 8'($urandom);
    endtask

    // FTDI host: the head byte leaves the chip on every edge that sees RD# and RXF# low.
    always @(posedge ftdiclk) begin
        host_cap = !reset && !ftdi_rd_n && !ftdi_rxf_n;
        #1;
        if (host_cap && host_q.size() != 0) void'(host_q.pop_front());
        host_drive();
    end

    // Monitor: judges each edge from the bus values that held just before it.
    always @(negedge ftdiclk) begin
        cur_s.rst = reset;       cur_s.rxf_n = ftdi_rxf_n; cur_s.inh = rx_inhibit;
        cur_s.m_ready = m_ready; cur_s.oe_n = ftdi_oe_n;   cur_s.rd_n = ftdi_rd_n;
        cur_s.busy = bus_busy;   cur_s.m_valid = m_valid;  cur_s.ovf = overflow;
        cur_s.data = ftdi_data_in; cur_s.m_data = m_data;
        if (mon_en && prev_s.rst) begin
            exp_q.delete();
        end else if (mon_en) begin
            mon_occ  = exp_q.size();
            mon_room = mon_occ < DEPTH - 2;
            tests++;
            if (!cur_s.rd_n && !(!prev_s.oe_n && !prev_s.rxf_n && !prev_s.inh)) begin
                fails++;
                $display("FAIL rd_assert_cond cyc %0d: rd_n=%b after oe_n=%b rxf_n=%b inh=%b, required rd_n=1",
                         cyc, cur_s.rd_n, prev_s.oe_n, prev_s.rxf_n, prev_s.inh);
            end
            tests++;
            if (!cur_s.rd_n && !prev_s.rd_n && !mon_room) begin
                fails++;
                $display("FAIL rd_headroom cyc %0d: rd_n stayed 0 with count %0d, required exit at %0d",
                         cyc, mon_occ, DEPTH - 2);
            end
            tests++;
            if (!cur_s.oe_n && (prev_s.rxf_n || prev_s.inh)) begin
                fails++;
                $display("FAIL oe_hold_cond cyc %0d: oe_n=%b after rxf_n=%b inh=%b, required oe_n=1",
                         cyc, cur_s.oe_n, prev_s.rxf_n, prev_s.inh);
            end
            tests++;
            if (!cur_s.oe_n && prev_s.oe_n && !(mon_room && cur_s.rd_n)) begin
                fails++;
                $display("FAIL oe_start cyc %0d: oe_n fell with count %0d rd_n=%b, required room and rd_n=1",
                         cyc, mon_occ, cur_s.rd_n);
            end
            tests++;
            if (!prev_s.rd_n && cur_s.rd_n && !cur_s.oe_n) begin
                fails++;
                $display("FAIL read_exit cyc %0d: oe_n=%b when rd_n released, required 1", cyc, cur_s.oe_n);
            end
            tests++;
            if (!prev_s.rxf_n && !prev_s.inh && mon_room &&
                !(!cur_s.oe_n && (!cur_s.rd_n || prev_s.oe_n))) begin
                fails++;
                $display("FAIL progress cyc %0d: oe_n %b->%b rd_n %b->%b with data, room, no inhibit",
                         cyc, prev_s.oe_n, cur_s.oe_n, prev_s.rd_n, cur_s.rd_n);
            end
            tests++;
            if (!prev_s.oe_n && prev_s.rd_n && !prev_s.rxf_n && !prev_s.inh && cur_s.rd_n) begin
                fails++;
                $display("FAIL turn_to_read cyc %0d: rd_n=%b after turnaround, required 0", cyc, cur_s.rd_n);
            end
            if (prev_s.m_ready && mon_occ != 0) got_q.push_back(exp_q.pop_front());
            if (!prev_s.rd_n && !prev_s.rxf_n) exp_q.push_back(prev_s.data);
        end
        if (mon_en) begin
            tests++;
            if (cur_s.m_valid !== (exp_q.size() != 0)) begin
                fails++;
                $display("FAIL m_valid cyc %0d: got %b, required %b", cyc, cur_s.m_valid, exp_q.size() != 0);
            end
            if (exp_q.size() != 0) begin
                tests++;
                if (cur_s.m_data !== exp_q[0]) begin
                    fails++;
                    $display("FAIL m_data cyc %0d: got %h, required %h", cyc, cur_s.m_data, exp_q[0]);
                end
            end
            tests++;
            if (cur_s.busy !== ~cur_s.oe_n || (!cur_s.rd_n && cur_s.oe_n)) begin
                fails++;
                $display("FAIL bus_busy cyc %0d: busy=%b oe_n=%b rd_n=%b", cyc, cur_s.busy, cur_s.oe_n, cur_s.rd_n);
            end
            tests++;
            if (cur_s.ovf !== 1'b0 || exp_q.size() > DEPTH - 1) begin
                fails++;
                $display("FAIL overflow cyc %0d: overflow=%b count=%0d, required 0 and <=%0d",
                         cyc, cur_s.ovf, exp_q.size(), DEPTH - 1);
            end
        end
        prev_s = cur_s;
        mon_en = 1'b1;
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge ftdiclk);
            #2;
        end
    endtask

    function automatic bit same_stream(input byte_q_t a, input byte_q_t b);
        if (a.size() != b.size()) return 1'b0;
        foreach (a[i]) if (a[i] !== b[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic drain(input string name, input int budget);
        m_ready = 1'b1; rx_inhibit = 1'b0; host_hold = 1'b0; host_drive();
        for (int i = 0; i < budget; i++) begin
            if (host_q.size() == 0 && exp_q.size() == 0 && ftdi_oe_n === 1'b1 && m_valid !== 1'b1) begin
                tick();
                return;
            end
            tick();
        end
        tests++; fails++;
        $display("FAIL %s_timeout: host left %0d, fifo %0d after %0d cycles", name, host_q.size(), exp_q.size(), budget);
    endtask

    task automatic test_reset();
        reset = 1'b1; m_ready = 1'b0; rx_inhibit = 1'b0; host_hold = 1'b0;
        tick(3);
        tests++; if (ftdi_oe_n !== 1'b1) begin fails++; $display("FAIL reset_oe_n: got %b, required 1", ftdi_oe_n); end
        tests++; if (ftdi_rd_n !== 1'b1) begin fails++; $display("FAIL reset_rd_n: got %b, required 1", ftdi_rd_n); end
        tests++; if (bus_busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b, required 0", bus_busy); end
        tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL reset_m_valid: got %b, required 0", m_valid); end
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow: got %b, required 0", overflow); end
        reset = 1'b0;
        tick(3);
        tests++; if (ftdi_oe_n !== 1'b1) begin fails++; $display("FAIL idle_oe_n: got %b, required 1", ftdi_oe_n); end
    endtask

    task automatic test_single_byte();
        got_q.delete(); m_ready = 1'b1;
        host_q.push_back(8'h45); host_drive();
        tick();
        tests++; if (ftdi_oe_n !== 1'b0 || ftdi_rd_n !== 1'b1) begin fails++;
            $display("FAIL single_edge1: oe_n=%b rd_n=%b, required 0/1", ftdi_oe_n, ftdi_rd_n); end
        tick();
        tests++; if (ftdi_oe_n !== 1'b0 || ftdi_rd_n !== 1'b0) begin fails++;
            $display("FAIL single_edge2: oe_n=%b rd_n=%b, required 0/0", ftdi_oe_n, ftdi_rd_n); end
        tick();
        tests++; if (m_valid !== 1'b1 || m_data !== 8'h45) begin fails++;
            $display("FAIL single_edge3: m_valid=%b m_data=%h, required 1/45", m_valid, m_data); end
        tick();
        tests++; if (m_valid !== 1'b0 || ftdi_oe_n !== 1'b1 || ftdi_rd_n !== 1'b1) begin fails++;
            $display("FAIL single_edge4: m_valid=%b oe_n=%b rd_n=%b, required 0/1/1", m_valid, ftdi_oe_n, ftdi_rd_n); end
        drain("single", 50);
    endtask

    task automatic test_burst();
        int run;
        got_q.delete(); sent_q.delete(); m_ready = 1'b1;
        for (int i = 0; i < 32; i++) sent_q.push_back(8'(i));
        host_q = sent_q; host_drive();
        for (int i = 0; i < 10 && m_valid !== 1'b1; i++) tick();
        run = 0;
        while (m_valid === 1'b1 && run < 100) begin run++; tick(); end
        tests++; if (run !== 32) begin fails++; $display("FAIL burst_gapless: m_valid high %0d cycles, required 32", run); end
        drain("burst", 100);
        tests++; if (!same_stream(got_q, sent_q)) begin fails++;
            $display("FAIL burst_stream: got %0d bytes, required %0d in order", got_q.size(), sent_q.size()); end
    endtask

    task automatic test_backpressure();
        got_q.delete(); sent_q.delete(); m_ready = 1'b0;
        for (int i = 0; i < 20; i++) sent_q.push_back(8'($urandom));
        host_q = sent_q; host_drive();
        tick(40);
        tests++; if (host_q.size() != 5) begin fails++;
            $display("FAIL bp_captured: %0d bytes taken, required 15", 20 - host_q.size()); end
        tests++; if (m_valid !== 1'b1 || m_data !== sent_q[0]) begin fails++;
            $display("FAIL bp_head: m_valid=%b m_data=%h, required 1/%h", m_valid, m_data, sent_q[0]); end
        for (int i = 0; i < 5; i++) begin
            tests++; if (ftdi_oe_n !== 1'b1 || ftdi_rd_n !== 1'b1) begin fails++;
                $display("FAIL bp_parked: oe_n=%b rd_n=%b, required 1/1", ftdi_oe_n, ftdi_rd_n); end
            tick();
        end
        drain("bp", 200);
        tests++; if (!same_stream(got_q, sent_q)) begin fails++;
            $display("FAIL bp_stream: got %0d bytes, required %0d in order", got_q.size(), sent_q.size()); end
    endtask

    task automatic test_inhibit();
        got_q.delete(); sent_q.delete(); m_ready = 1'b1;
        for (int i = 0; i < 24; i++) sent_q.push_back(8'($urandom));
        host_q = sent_q; host_drive();
        for (int i = 0; i < 10 && ftdi_rd_n !== 1'b0; i++) tick();
        tick(3);
        rx_inhibit = 1'b1;
        tick();
        tests++; if (ftdi_oe_n !== 1'b1 || ftdi_rd_n !== 1'b1) begin fails++;
            $display("FAIL inh_release: oe_n=%b rd_n=%b, required 1/1", ftdi_oe_n, ftdi_rd_n); end
        tick(2);
        tests++; if (ftdi_oe_n !== 1'b1 || ftdi_rd_n !== 1'b1) begin fails++;
            $display("FAIL inh_hold: oe_n=%b rd_n=%b, required 1/1", ftdi_oe_n, ftdi_rd_n); end
        rx_inhibit = 1'b0;
        tick();
        tests++; if (ftdi_oe_n !== 1'b0 || ftdi_rd_n !== 1'b1) begin fails++;
            $display("FAIL inh_turn: oe_n=%b rd_n=%b, required 0/1", ftdi_oe_n, ftdi_rd_n); end
        tick();
        tests++; if (ftdi_rd_n !== 1'b0) begin fails++; $display("FAIL inh_resume: rd_n=%b, required 0", ftdi_rd_n); end
        drain("inh", 100);
        tests++; if (!same_stream(got_q, sent_q)) begin fails++;
            $display("FAIL inh_stream: got %0d bytes, required %0d in order", got_q.size(), sent_q.size()); end
    endtask

    task automatic test_rxf_turn();
        got_q.delete(); sent_q.delete(); m_ready = 1'b1;
        sent_q.push_back(8'($urandom));
        host_q = sent_q; host_drive();
        tick();
        tests++; if (ftdi_oe_n !== 1'b0 || bus_busy !== 1'b1) begin fails++;
            $display("FAIL turn_enter: oe_n=%b busy=%b, required 0/1", ftdi_oe_n, bus_busy); end
        host_hold = 1'b1; host_drive();
        tick();
        tests++; if (ftdi_oe_n !== 1'b1 || ftdi_rd_n !== 1'b1 || bus_busy !== 1'b0 || m_valid !== 1'b0) begin fails++;
            $display("FAIL turn_abort: oe_n=%b rd_n=%b busy=%b m_valid=%b, required 1/1/0/0",
                     ftdi_oe_n, ftdi_rd_n, bus_busy, m_valid); end
        tick(3);
        tests++; if (ftdi_oe_n !== 1'b1 || ftdi_rd_n !== 1'b1) begin fails++;
            $display("FAIL turn_idle: oe_n=%b rd_n=%b, required 1/1", ftdi_oe_n, ftdi_rd_n); end
        drain("turn", 50);
        tests++; if (!same_stream(got_q, sent_q)) begin fails++;
            $display("FAIL turn_stream: got %0d bytes, required 1", got_q.size()); end
    endtask

    task automatic test_reset_mid();
        byte_q_t tail;
        got_q.delete(); sent_q.delete(); m_ready = 1'b0;
        for (int i = 0; i < 8; i++) sent_q.push_back(8'($urandom));
        host_q = sent_q; host_drive();
        for (int i = 0; i < 30 && host_q.size() != 3; i++) tick();
        tests++; if (m_valid !== 1'b1 || ftdi_rd_n !== 1'b0) begin fails++;
            $display("FAIL rst_pre: m_valid=%b rd_n=%b with 5 buffered, required 1/0", m_valid, ftdi_rd_n); end
        reset = 1'b1;
        tick();
        tests++; if (ftdi_oe_n !== 1'b1 || ftdi_rd_n !== 1'b1 || m_valid !== 1'b0 || overflow !== 1'b0) begin fails++;
            $display("FAIL rst_mid: oe_n=%b rd_n=%b m_valid=%b overflow=%b, required 1/1/0/0",
                     ftdi_oe_n, ftdi_rd_n, m_valid, overflow); end
        tests++; if (host_q.size() != 3) begin fails++;
            $display("FAIL rst_nocap: host has %0d left, required 3", host_q.size()); end
        reset = 1'b0; got_q.delete();
        for (int i = 5; i < 8; i++) tail.push_back(sent_q[i]);
        drain("rst", 100);
        tests++; if (!same_stream(got_q, tail)) begin fails++;
            $display("FAIL rst_stream: got %0d bytes, required 3 fresh in order", got_q.size()); end
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) begin
            got_q.delete(); sent_q.delete();
            for (int i = 0; i < int'($urandom_range(1, 40)); i++) sent_q.push_back(8'($urandom));
            host_q = sent_q; host_drive();
            for (int c = 0; c < 3000; c++) begin
                if (host_q.size() == 0 && exp_q.size() == 0 && m_valid !== 1'b1) break;
                m_ready    = $urandom_range(0, 3) != 0;
                rx_inhibit = $urandom_range(0, 15) == 0;
                host_hold  = $urandom_range(0, 7) == 0;
                host_drive();
                tick();
            end
            drain("random", 200);
            tests++; if (!same_stream(got_q, sent_q)) begin fails++;
                $display("FAIL random_stream round %0d: got %0d bytes, required %0d in order",
                         r, got_q.size(), sent_q.size()); end
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_burst();
        test_backpressure();
        test_inhibit();
        test_rxf_turn();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, %0d failed so far", fails);
        $fatal(1);
    end

endmodule
